pmod_step_sequencer: RTL and testbench

//  Move controller for the PMOD stepper driver. Takes a move command (step count, direction, step period).

---
 rtl/pmod_step_sequencer_if.sv | 27 ++
 rtl/pmod_step_sequencer.sv | 164 ++++++++++++++++
 tb/tb_pmod_step_sequencer.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/pmod_step_sequencer_if.sv
// Command and status bundle between move-control logic (master) and the step sequencer (slave).
interface pmod_step_sequencer_if #(
    parameter int STEP_W   = 16,
    parameter int PERIOD_W = 24
);
    logic                start;
    logic [STEP_W-1:0]   steps;
    logic                dir_in;
    logic [PERIOD_W-1:0] period;
    logic                abort;
    logic                drv_step;
    logic                drv_en;
    logic                drv_dir;
    logic                busy;
    logic                done;
    logic [STEP_W-1:0]   steps_left;

    modport master (
        output start, steps, dir_in, period, abort,
        input  drv_step, drv_en, drv_dir, busy, done, steps_left
    );

    modport slave (
        input  start, steps, dir_in, period, abort,
        output drv_step, drv_en, drv_dir, busy, done, steps_left
    );
endinterface

// File: rtl/pmod_step_sequencer.sv
// Move controller for the PMOD full-step driver: turns a move command into step pulses, enable and direction.
// Optional feature macro ACCEL_RAMP_EN adds a linear start ramp from 4x the requested period down to it.
module pmod_step_sequencer #(
    parameter int STEP_W   = 16,
    parameter int PERIOD_W = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pmod_step_sequencer_if.slave  bus
);

`ifdef ACCEL_RAMP_EN
    // The ramp starts at 4x the period, so the live period and its counter need two extra bits.
    localparam int CUR_W = PERIOD_W + 2;
`else
    localparam int CUR_W = PERIOD_W;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CUR_W-1:0]    cur_period_q, cur_period_d;
    logic [CUR_W-1:0]    cnt_q, cnt_d;
    logic [STEP_W-1:0]   steps_left_q, steps_left_d;
    logic                drv_step_q, drv_step_d;
    logic                drv_en_q, drv_en_d;
    logic                drv_dir_q, drv_dir_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [PERIOD_W-1:0] period_sat;
    logic [CUR_W-1:0]    period_load;
    logic                step_due;

    assign period_sat = (bus.period == '0) ? PERIOD_W'(1) : bus.period;
    assign step_due   = (cnt_q == (cur_period_q - CUR_W'(1)));

`ifdef ACCEL_RAMP_EN
    logic [PERIOD_W-1:0] base_q, base_d;
    logic [CUR_W-1:0]    base_ext;
    logic [CUR_W-1:0]    ramp_dec;
    logic [CUR_W-1:0]    ramp_next;

    assign period_load = {period_sat, 2'b00};
    assign base_ext    = CUR_W'(base_q);
    // cur_period never drops below the base, so subtracting base/4 cannot underflow.
    assign ramp_dec    = cur_period_q - CUR_W'(base_q >> 2);
    assign ramp_next   = (ramp_dec < base_ext) ? base_ext : ramp_dec;
`else
    assign period_load = CUR_W'(period_sat);
`endif

    always_comb begin
        state_d      = state_q;
        cur_period_d = cur_period_q;
        cnt_d        = cnt_q;
        steps_left_d = steps_left_q;
        drv_dir_d    = drv_dir_q;
        drv_step_d   = 1'b0;
        drv_en_d     = 1'b0;
        busy_d       = 1'b0;
        done_d       = 1'b0;
`ifdef ACCEL_RAMP_EN
        base_d       = base_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    steps_left_d = bus.steps;
                    cnt_d        = '0;
                    if (bus.steps != '0) begin
                        state_d      = S_RUN;
                        drv_dir_d    = bus.dir_in;
                        cur_period_d = period_load;
`ifdef ACCEL_RAMP_EN
                        base_d       = period_sat;
`endif
                        drv_en_d     = 1'b1;
                        busy_d       = 1'b1;
                    end else begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end
            end

            S_RUN: begin
                // Abort wins over a step falling due on the same edge.
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else if (step_due) begin
                    drv_step_d   = 1'b1;
                    cnt_d        = '0;
                    steps_left_d = steps_left_q - STEP_W'(1);
`ifdef ACCEL_RAMP_EN
                    cur_period_d = ramp_next;
`endif
                    if (steps_left_q == STEP_W'(1)) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        drv_en_d = 1'b1;
                        busy_d   = 1'b1;
                    end
                end else begin
                    cnt_d    = cnt_q + CUR_W'(1);
                    drv_en_d = 1'b1;
                    busy_d   = 1'b1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cur_period_q <= '0;
            cnt_q        <= '0;
            steps_left_q <= '0;
            drv_step_q   <= 1'b0;
            drv_en_q     <= 1'b0;
            drv_dir_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef ACCEL_RAMP_EN
            base_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cur_period_q <= cur_period_d;
            cnt_q        <= cnt_d;
            steps_left_q <= steps_left_d;
            drv_step_q   <= drv_step_d;
            drv_en_q     <= drv_en_d;
            drv_dir_q    <= drv_dir_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
`ifdef ACCEL_RAMP_EN
            base_q       <= base_d;
`endif
        end
    end

    assign bus.drv_step   = drv_step_q;
    assign bus.drv_en     = drv_en_q;
    assign bus.drv_dir    = drv_dir_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.steps_left = steps_left_q;

endmodule

// File: tb/tb_pmod_step_sequencer.sv
// Bench for pmod_step_sequencer: table of directed moves, random moves, and a mid-move reset,
// each checked cycle by cycle against pulse times derived from the period/ramp rules.
module tb_pmod_step_sequencer;
    localparam int STEP_W   = 16;
    localparam int PERIOD_W = 24;

`ifdef ACCEL_RAMP_EN
    localparam bit RAMP = 1'b1;
`else
    localparam bit RAMP = 1'b0;
`endif

    // glitchAt: observation cycle carrying a stray start (-1 none, -2 the done cycle).
    typedef struct {
        int unsigned steps;
        int unsigned period;
        bit          dir;
        int          abortAfter;
        int          glitchAt;
        bit          abortWithStart;
        int unsigned expPulses;
        int unsigned expLeft;
        bit          expDone;
    } vector_t;

    logic clk = 1'b0;
    logic rst_n;

    pmod_step_sequencer_if #(.STEP_W(STEP_W), .PERIOD_W(PERIOD_W)) bus ();

    pmod_step_sequencer #(.STEP_W(STEP_W), .PERIOD_W(PERIOD_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int vectorCount = 0;
    int missCount   = 0;
    bit dirModel    = 1'b0;

    // Clock count between step k-1 and step k for base period p.
    function automatic longint gapOf(input longint p, input int k);
        longint g;
        g = p;
        if (RAMP) begin
            g = 4 * p - longint'(k - 1) * (p / 4);
            if (g < p) g = p;
        end
        return g;
    endfunction

    task automatic checkOutput(input string name, input longint j, input bit eStep, input bit eBusy,
                               input bit eDone, input bit eEn, input bit eDir, input int unsigned eLeft);
        logic [STEP_W+4:0] act;
        logic [STEP_W+4:0] exp;
        act = {bus.drv_step, bus.busy, bus.done, bus.drv_en, bus.drv_dir, bus.steps_left};
        exp = {eStep, eBusy, eDone, eEn, eDir, STEP_W'(eLeft)};
        vectorCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s j=%0d: got step/busy/done/en/dir=%b%b%b%b%b left=%0d, want %b%b%b%b%b left=%0d",
                     name, j, act[STEP_W+4], act[STEP_W+3], act[STEP_W+2], act[STEP_W+1], act[STEP_W],
                     act[STEP_W-1:0], eStep, eBusy, eDone, eEn, eDir, eLeft);
        end
    endtask

    task automatic checkCount(input string name, input longint act, input longint exp);
        vectorCount++;
        if (act != exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vector_t v, input string name);
        longint pulseAt[$];
        longint p, t, endJ, abortJ, lastJ, glitchJ;
        longint nPulses;
        bit     isPulse, aborted, eBusy, eDir;
        int     pulsesSeen;
        bit     doneSeen;

        p = (v.period == 0) ? 1 : longint'(v.period);
        t = 0;
        for (int k = 1; k <= int'(v.steps); k++) begin
            t += gapOf(p, k);
            pulseAt.push_back(t);
        end
        endJ    = t;
        abortJ  = (v.abortAfter > 0) ? pulseAt[v.abortAfter - 1] : -1;
        lastJ   = (abortJ >= 0) ? abortJ + 2 : endJ + 1;
        glitchJ = (v.glitchAt == -2) ? endJ : longint'(v.glitchAt);
        pulsesSeen = 0;
        doneSeen   = 1'b0;

        @(negedge clk);
        bus.start  = 1'b1;
        bus.steps  = STEP_W'(v.steps);
        bus.dir_in = v.dir;
        bus.period = PERIOD_W'(v.period);
        bus.abort  = v.abortWithStart;

        for (longint j = 0; j <= lastJ; j++) begin
            @(negedge clk);
            aborted = (abortJ >= 0) && (j > abortJ);
            nPulses = 0;
            isPulse = 1'b0;
            foreach (pulseAt[i]) begin
                if (pulseAt[i] <= j) nPulses++;
                if (pulseAt[i] == j) isPulse = 1'b1;
            end
            eDir = (v.steps != 0) ? v.dir : dirModel;
            if (aborted) begin
                checkOutput(name, j, 1'b0, 1'b0, 1'b0, 1'b0, eDir, v.steps - v.abortAfter);
            end else begin
                eBusy = (v.steps != 0) && (j < endJ);
                checkOutput(name, j, isPulse, eBusy, j == endJ, eBusy, eDir, v.steps - int'(nPulses));
            end
            pulsesSeen += int'(bus.drv_step);
            doneSeen   |= bus.done;

            bus.start = 1'b0;
            bus.abort = (j == abortJ);
            if (j == glitchJ && j <= endJ && j < lastJ) begin
                bus.start  = 1'b1;
                bus.steps  = STEP_W'(2);
                bus.dir_in = ~v.dir;
                bus.period = PERIOD_W'(3);
            end
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;

        checkCount({name, " pulses"}, pulsesSeen, v.expPulses);
        checkCount({name, " done seen"}, doneSeen, v.expDone);
        checkCount({name, " final steps_left"}, bus.steps_left, v.expLeft);
        if (v.steps != 0) dirModel = v.dir;
    endtask

    task automatic resetMidMove();
        @(negedge clk);
        bus.start  = 1'b1;
        bus.steps  = STEP_W'(10);
        bus.dir_in = 1'b1;
        bus.period = PERIOD_W'(5);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (12) @(negedge clk);
        checkOutput("mid-move before reset", 13, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("reset mid-move", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        dirModel = 1'b0;
        repeat (6) @(negedge clk);
        checkOutput("idle after reset", 6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    endtask

    initial begin
        vector_t vecs[10];
        vector_t rv;

        vecs[0] = '{4,      10, 1'b1, -1, -1, 1'b0, 4,  0,     1'b1};
        vecs[1] = '{0,      10, 1'b1, -1, -1, 1'b0, 0,  0,     1'b1};
        vecs[2] = '{100,    8,  1'b0, 3,  -1, 1'b0, 3,  97,    1'b0};
        vecs[3] = '{5,      6,  1'b1, -1, 9,  1'b0, 5,  0,     1'b1};
        vecs[4] = '{14,     8,  1'b1, -1, -1, 1'b0, 14, 0,     1'b1};
        vecs[5] = '{3,      0,  1'b0, -1, -1, 1'b0, 3,  0,     1'b1};
        vecs[6] = '{4,      1,  1'b1, -1, -1, 1'b0, 4,  0,     1'b1};
        vecs[7] = '{5,      1,  1'b0, 2,  -1, 1'b0, 2,  3,     1'b0};
        vecs[8] = '{3,      4,  1'b1, -1, -2, 1'b1, 3,  0,     1'b1};
        vecs[9] = '{65535,  2,  1'b1, 2,  -1, 1'b0, 2,  65533, 1'b0};

        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.steps  = '0;
        bus.dir_in = 1'b0;
        bus.period = '0;
        bus.abort  = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset state", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        rst_n = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        checkOutput("idle ignores abort", 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
        end

        resetMidMove();
        rv = '{6, 3, 1'b1, -1, -1, 1'b0, 6, 0, 1'b1};
        applyStimulus(rv, "after reset");

        for (int i = 0; i < 25; i++) begin
            rv.steps          = $urandom_range(0, 12);
            rv.period         = $urandom_range(0, 9);
            rv.dir            = 1'($urandom_range(0, 1));
            rv.abortWithStart = ($urandom_range(0, 3) == 0);
            rv.abortAfter     = -1;
            rv.glitchAt       = -1;
            if (rv.steps >= 2 && $urandom_range(0, 2) == 0) begin
                rv.abortAfter = $urandom_range(1, rv.steps - 1);
            end else if ($urandom_range(0, 3) == 0) begin
                rv.glitchAt = ($urandom_range(0, 1) == 0) ? -2 : int'($urandom_range(0, 20));
            end
            rv.expPulses = (rv.abortAfter > 0) ? rv.abortAfter : rv.steps;
            rv.expLeft   = rv.steps - rv.expPulses;
            rv.expDone   = (rv.abortAfter <= 0);
            applyStimulus(rv, $sformatf("rand%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
